// File: rtl/taxi_eth_link_mon.sv
// Multi-channel Ethernet link monitor: qualifies raw link status, counts flaps,
// stretches activity pulses and multiplexes a selectable source onto the LED bus.
module taxi_eth_link_mon #(
    parameter int CH_CNT         = 4,
    parameter int STATUS_W       = 16,
    parameter int LED_W          = 8,
    parameter int QUAL_CYCLES    = 125000,
    parameter int STRETCH_CYCLES = 6250000,
    parameter int CNT_W          = 16,
    localparam int SEL_CH_W      = (CH_CNT > 1) ? $clog2(CH_CNT) : 1,
    localparam int BYTE_CNT      = STATUS_W / LED_W,
    localparam int SEL_BYTE_W    = (BYTE_CNT > 1) ? $clog2(BYTE_CNT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CH_CNT*STATUS_W-1:0] status_in,
    input  logic [CH_CNT-1:0]          link_raw,
    input  logic [CH_CNT-1:0]          act_in,
    input  logic                       clr_cnt,
    input  logic [1:0]                 sel_mode,
    input  logic [SEL_CH_W-1:0]        sel_ch,
    input  logic [SEL_BYTE_W-1:0]      sel_byte,
    input  logic [LED_W-1:0]           led_in,
    output logic [LED_W-1:0]           led,
    output logic [CH_CNT-1:0]          link_up,
    output logic [CH_CNT-1:0]          act,
    output logic [CH_CNT*CNT_W-1:0]    flap_cnt
);

    typedef enum logic [1:0] {
        MODE_USER    = 2'd0,
        MODE_STATUS  = 2'd1,
        MODE_SUMMARY = 2'd2,
        MODE_FLAP    = 2'd3
    } led_mode_e;

    localparam int QW    = $clog2(QUAL_CYCLES + 1);
    localparam int SW    = $clog2(STRETCH_CYCLES + 1);
    localparam int SUM_W = 2 * CH_CNT;

    localparam logic [QW-1:0]    Q_MAX   = QW'(QUAL_CYCLES);
    localparam logic [SW-1:0]    S_MAX   = SW'(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [QW-1:0]    r_q     [CH_CNT];
    logic [SW-1:0]    r_s     [CH_CNT];
    logic [CNT_W-1:0] r_flap  [CH_CNT];
    logic [CH_CNT-1:0] r_link_up;
    logic [CH_CNT-1:0] r_act;
    logic [LED_W-1:0]  r_led;

    logic [QW-1:0]    w_q_nxt    [CH_CNT];
    logic [SW-1:0]    w_s_nxt    [CH_CNT];
    logic [CNT_W-1:0] w_flap_nxt [CH_CNT];
    logic [CH_CNT-1:0] w_link_nxt;
    logic [CH_CNT-1:0] w_act_nxt;
    logic [CH_CNT-1:0] w_fall;
    logic [SUM_W-1:0]  w_sum;
    logic [LED_W-1:0]  w_summary;
    logic [LED_W-1:0]  w_led_nxt;

    // Per-channel next state; link_up and act are registered copies of the
    // next-state predicates so they change on the same edge as their counters.
    always_comb begin
        for (int c = 0; c < CH_CNT; c++) begin
            w_q_nxt[c] = '0;
            if (link_raw[c]) begin
                w_q_nxt[c] = (r_q[c] == Q_MAX) ? Q_MAX : r_q[c] + 1'b1;
            end
            w_link_nxt[c] = (w_q_nxt[c] == Q_MAX);
            w_fall[c]     = r_link_up[c] & ~w_link_nxt[c];

            w_s_nxt[c] = '0;
            if (act_in[c]) begin
                w_s_nxt[c] = S_MAX;
            end else if (r_s[c] != '0) begin
                w_s_nxt[c] = r_s[c] - 1'b1;
            end
            w_act_nxt[c] = (w_s_nxt[c] != '0);

            // Clear has priority over a flap arriving in the same cycle.
            w_flap_nxt[c] = r_flap[c];
            if (clr_cnt) begin
                w_flap_nxt[c] = '0;
            end else if (w_fall[c] && r_flap[c] != CNT_MAX) begin
                w_flap_nxt[c] = r_flap[c] + 1'b1;
            end
        end
    end

    assign w_sum = {r_act, r_link_up};

    generate
        if (SUM_W >= LED_W) begin : g_sum_trunc
            assign w_summary = w_sum[LED_W-1:0];
        end else begin : g_sum_pad
            assign w_summary = {{(LED_W - SUM_W){1'b0}}, w_sum};
        end
    endgenerate

    // Out-of-range channel/byte selects match no loop iteration and leave 0.
    always_comb begin
        w_led_nxt = '0;
        case (led_mode_e'(sel_mode))
            MODE_USER: w_led_nxt = led_in;
            MODE_STATUS: begin
                for (int c = 0; c < CH_CNT; c++) begin
                    for (int b = 0; b < BYTE_CNT; b++) begin
                        if (sel_ch == SEL_CH_W'(c) && sel_byte == SEL_BYTE_W'(b)) begin
                            w_led_nxt = status_in[c*STATUS_W + b*LED_W +: LED_W];
                        end
                    end
                end
            end
            MODE_SUMMARY: w_led_nxt = w_summary;
            MODE_FLAP: begin
                for (int c = 0; c < CH_CNT; c++) begin
                    if (sel_ch == SEL_CH_W'(c)) begin
                        w_led_nxt = r_flap[c][LED_W-1:0];
                    end
                end
            end
            default: w_led_nxt = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every channel
    // samples the same pre-edge values; the small counter arrays are reset
    // explicitly because mid-operation reset must discard in-progress state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_link_up <= '0;
            r_act     <= '0;
            r_led     <= '0;
            for (int c = 0; c < CH_CNT; c++) begin
                r_q[c]    <= '0;
                r_s[c]    <= '0;
                r_flap[c] <= '0;
            end
        end else begin
            r_link_up <= w_link_nxt;
            r_act     <= w_act_nxt;
            r_led     <= w_led_nxt;
            for (int c = 0; c < CH_CNT; c++) begin
                r_q[c]    <= w_q_nxt[c];
                r_s[c]    <= w_s_nxt[c];
                r_flap[c] <= w_flap_nxt[c];
            end
        end
    end

    generate
        for (genvar c = 0; c < CH_CNT; c++) begin : g_flap_out
            assign flap_cnt[c*CNT_W +: CNT_W] = r_flap[c];
        end
    endgenerate

    assign led     = r_led;
    assign link_up = r_link_up;
    assign act     = r_act;

endmodule
